// File: rtl/coproc_cmd_pkg.sv
// Shared definitions for the HPS PIO command bridge: word layouts, opcodes, error codes, FSM states.
package coproc_cmd_pkg;

  localparam int unsigned CMD_W = 19;
  localparam int unsigned STS_W = 10;

  localparam int unsigned CmdReqBit  = 18;
  localparam int unsigned CmdOpcMsb  = 17;
  localparam int unsigned CmdOpcLsb  = 14;
  localparam int unsigned CmdAddrMsb = 13;
  localparam int unsigned CmdAddrLsb = 8;
  localparam int unsigned CmdDataMsb = 7;
  localparam int unsigned CmdDataLsb = 0;

  localparam int unsigned StsAckBit   = 9;
  localparam int unsigned StsErrBit   = 8;
  localparam int unsigned StsRdataMsb = 7;
  localparam int unsigned StsRdataLsb = 0;

  typedef enum logic [3:0] {
    OpNop       = 4'd0,
    OpLoadA     = 4'd1,
    OpLoadB     = 4'd2,
    OpReadC     = 4'd3,
    OpAdd       = 4'd4,
    OpSub       = 4'd5,
    OpMulScalar = 4'd6,
    OpMul       = 4'd7,
    OpTranspose = 4'd8
  } opcode_e;

  localparam logic [3:0] OPC_MAX = 4'd8;

  localparam logic [7:0] ERR_ILLEGAL = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StAck
  } state_e;

  function automatic logic opc_legal(input logic [3:0] opc);
    return opc <= OPC_MAX;
  endfunction

endpackage

// File: rtl/pio_cmd_bridge_if.sv
// Valid/ready command channel and response strobe between the bridge and the matrix coprocessor.
interface pio_cmd_bridge_if;

  logic       co_valid;
  logic       co_ready;
  logic [3:0] co_op;
  logic [5:0] co_addr;
  logic [7:0] co_data;
  logic       co_rsp_valid;
  logic [7:0] co_rsp_data;
  logic       co_rsp_err;

  modport master (
    output co_valid,
    output co_op,
    output co_addr,
    output co_data,
    input  co_ready,
    input  co_rsp_valid,
    input  co_rsp_data,
    input  co_rsp_err
  );

  modport slave (
    input  co_valid,
    input  co_op,
    input  co_addr,
    input  co_data,
    output co_ready,
    output co_rsp_valid,
    output co_rsp_data,
    output co_rsp_err
  );

endinterface

// File: rtl/pio_cmd_decode.sv
// Combinational split of the PIO command word into fields plus opcode legality/NOP flags.
module pio_cmd_decode
  import coproc_cmd_pkg::*;
(
  input  logic [CMD_W-1:0] cmd_word_i,
  output logic             req_o,
  output logic [3:0]       opc_o,
  output logic [5:0]       addr_o,
  output logic [7:0]       data_o,
  output logic             legal_o,
  output logic             nop_o
);

  always_comb begin
    req_o   = cmd_word_i[CmdReqBit];
    opc_o   = cmd_word_i[CmdOpcMsb:CmdOpcLsb];
    addr_o  = cmd_word_i[CmdAddrMsb:CmdAddrLsb];
    data_o  = cmd_word_i[CmdDataMsb:CmdDataLsb];
    legal_o = opc_legal(opc_o);
    nop_o   = (opc_o == OpNop);
  end

endmodule

// File: rtl/pio_cmd_bridge.sv
// HPS PIO command bridge: REQ/ACK handshake with software, valid/ready issue to the coprocessor.
module pio_cmd_bridge
  import coproc_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [CMD_W-1:0] cmd_word,
  output logic [STS_W-1:0] sts_word,
  pio_cmd_bridge_if.master co,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic       dec_req;
  logic [3:0] dec_opc;
  logic [5:0] dec_addr;
  logic [7:0] dec_data;
  logic       dec_legal;
  logic       dec_nop;

  pio_cmd_decode u_decode (
    .cmd_word_i (cmd_word),
    .req_o      (dec_req),
    .opc_o      (dec_opc),
    .addr_o     (dec_addr),
    .data_o     (dec_data),
    .legal_o    (dec_legal),
    .nop_o      (dec_nop)
  );

  state_e            state_q, state_d;
  logic              req_q;
  logic [3:0]        op_q, op_d;
  logic [5:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_rise;

  // req_q resets high so a REQ held across reset release is not taken as a new request.
  assign req_rise = dec_req && !req_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_rise) begin
          op_d   = dec_opc;
          addr_d = dec_addr;
          data_d = dec_data;
          if (!dec_legal) begin
            err_d   = 1'b1;
            rdata_d = ERR_ILLEGAL;
            state_d = StAck;
          end else if (dec_nop) begin
            err_d   = 1'b0;
            rdata_d = 8'h00;
            state_d = StAck;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (co.co_ready) begin
          tmo_d   = '0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (co.co_rsp_valid) begin
          err_d   = co.co_rsp_err;
          rdata_d = co.co_rsp_data;
          state_d = StAck;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          rdata_d = ERR_TIMEOUT;
          state_d = StAck;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StAck: begin
        if (!dec_req) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= StIdle;
      req_q   <= 1'b1;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= dec_req;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign co.co_valid = (state_q == StIssue);
  assign co.co_op    = op_q;
  assign co.co_addr  = addr_q;
  assign co.co_data  = data_q;

  always_comb begin
    sts_word                          = '0;
    sts_word[StsAckBit]               = (state_q == StAck);
    sts_word[StsErrBit]               = err_q;
    sts_word[StsRdataMsb:StsRdataLsb] = rdata_q;
  end

  assign cmd_count = cnt_q;

endmodule
